// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and
// a selectable read mode (registered read or first-word-fall-through).
// Producer and consumer share clk; there is no clock-domain crossing here.
//
// Handshake: the producer offers a word with wr; it is taken at the rising
// edge only when the FIFO is not full (wr_acc). The consumer requests with
// rd; it is honoured at the rising edge only when the FIFO is not empty
// (rd_acc). Both decisions use the state from before that edge, so a write
// into an empty FIFO and a read from a full FIFO in the same cycle each see
// the old state: at empty only the write goes through, at full only the read.
// A refused request is dropped, not held, and raises the matching sticky
// error flag.
module sync_fifo_flags #(
  parameter int addr_size  = 3,
  parameter int word_width = 8,
  parameter int af_thr     = 6,
  parameter int ae_thr     = 1,
  parameter int fwft       = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic [word_width-1:0] data_in,
  input  logic                  rd,
  input  logic                  err_clr,
  output logic [word_width-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [addr_size:0]    count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** addr_size;

  // Thresholds and depth resized to the count width so every flag compare
  // is between equal-width unsigned values.
  localparam logic [addr_size:0] DEPTH_C = (addr_size + 1)'(DEPTH);
  localparam logic [addr_size:0] AF_C    = (addr_size + 1)'(af_thr);
  localparam logic [addr_size:0] AE_C    = (addr_size + 1)'(ae_thr);

  // Illegal thresholds would give flags that can never (or always) assert;
  // stop elaboration instead of building a misleading FIFO.
  if (af_thr < 1 || af_thr > DEPTH) begin : g_bad_af_thr
    $error("sync_fifo_flags: af_thr must lie in 1..DEPTH");
  end
  if (ae_thr < 0 || ae_thr > DEPTH - 1) begin : g_bad_ae_thr
    $error("sync_fifo_flags: ae_thr must lie in 0..DEPTH-1");
  end
  if (fwft != 0 && fwft != 1) begin : g_bad_fwft
    $error("sync_fifo_flags: fwft must be 0 or 1");
  end

  // Storage; deliberately not reset, only the pointers define what is valid.
  logic [word_width-1:0] mem_q [DEPTH];

  // Pointers carry one extra wrap bit above the memory index.
  logic [addr_size:0] wr_ptr_q, wr_ptr_d;
  logic [addr_size:0] rd_ptr_q, rd_ptr_d;
  logic [addr_size:0] count_q,  count_d;

  logic full_q,  full_d;
  logic empty_q, empty_d;
  logic af_q,    af_d;
  logic ae_q,    ae_d;
  logic ovf_q,   ovf_d;
  logic udf_q,   udf_d;

  logic wr_acc;
  logic rd_acc;

  logic [addr_size-1:0]  wr_idx;
  logic [addr_size-1:0]  rd_idx;
  logic [word_width-1:0] rd_word;

  assign wr_acc  = wr & ~full_q;
  assign rd_acc  = rd & ~empty_q;
  assign wr_idx  = wr_ptr_q[addr_size-1:0];
  assign rd_idx  = rd_ptr_q[addr_size-1:0];
  assign rd_word = mem_q[rd_idx];

  // Next-state for pointers, occupancy, status flags and sticky errors.
  // Flags are computed from the next count so they change on the same edge
  // as the count itself.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    count_d = count_q + (addr_size + 1)'(wr_acc) - (addr_size + 1)'(rd_acc);

    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);

    // A clear in the same cycle as a fresh error wins.
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end else begin
      if (wr && full_q) begin
        ovf_d = 1'b1;
      end
      if (rd && empty_q) begin
        udf_d = 1'b1;
      end
    end
  end

  // Control and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Memory write; a reset edge suppresses any write offered with it.
  always_ff @(posedge clk) begin
    if (reset_n && wr_acc) begin
      mem_q[wr_idx] <= data_in;
    end
  end

  if (fwft == 0) begin : g_std_read
    logic [word_width-1:0] dout_q;

    // Registered read: the head word is captured on an accepted read and
    // held otherwise, including across refused reads.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        dout_q <= '0;
      end else if (rd_acc) begin
        dout_q <= rd_word;
      end
    end

    assign data_out = dout_q;
  end else begin : g_fwft_read
    // Fall-through read: the head word is visible while the FIFO holds data
    // and forced to zero when empty, so stale memory never shows.
    assign data_out = empty_q ? '0 : rd_word;
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: a registered-read instance and a
// first-word-fall-through instance receive identical stimulus and are both
// compared each cycle against a queue-based model of FIFO behaviour.
module tb_sync_fifo_flags;

  localparam int AW    = 3;
  localparam int W     = 8;
  localparam int DEPTH = 2 ** AW;
  localparam int AF    = 6;
  localparam int AE    = 1;

  // Clock and shared inputs
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n = 1'b0;
  logic         wr      = 1'b0;
  logic         rd      = 1'b0;
  logic         err_clr = 1'b0;
  logic [W-1:0] data_in = '0;

  // Registered-read instance outputs
  logic [W-1:0] dout_s;
  logic         full_s, empty_s, af_s, ae_s, ovf_s, udf_s;
  logic [AW:0]  count_s;

  // Fall-through instance outputs
  logic [W-1:0] dout_f;
  logic         full_f, empty_f, af_f, ae_f, ovf_f, udf_f;
  logic [AW:0]  count_f;

  sync_fifo_flags #(
    .addr_size(AW), .word_width(W), .af_thr(AF), .ae_thr(AE), .fwft(0)
  ) dut_std (
    .clk(clk), .reset_n(reset_n), .wr(wr), .data_in(data_in), .rd(rd),
    .err_clr(err_clr), .data_out(dout_s), .full(full_s), .empty(empty_s),
    .almost_full(af_s), .almost_empty(ae_s), .count(count_s),
    .overflow(ovf_s), .underflow(udf_s)
  );

  sync_fifo_flags #(
    .addr_size(AW), .word_width(W), .af_thr(AF), .ae_thr(AE), .fwft(1)
  ) dut_fwft (
    .clk(clk), .reset_n(reset_n), .wr(wr), .data_in(data_in), .rd(rd),
    .err_clr(err_clr), .data_out(dout_f), .full(full_f), .empty(empty_f),
    .almost_full(af_f), .almost_empty(ae_f), .count(count_f),
    .overflow(ovf_f), .underflow(udf_f)
  );

  // Scoreboard: model contents, sticky errors, registered read word
  logic [W-1:0] exp_q[$];
  logic         exp_ovf    = 1'b0;
  logic         exp_udf    = 1'b0;
  logic [W-1:0] exp_dout_s = '0;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Compare every output of both instances with the model.
  task automatic check_all();
    int           n;
    logic [W-1:0] head;
    n    = exp_q.size();
    head = (n > 0) ? exp_q[0] : '0;
    chk("std.count",        32'(count_s), 32'(n));
    chk("std.full",         32'(full_s),  32'(n == DEPTH));
    chk("std.empty",        32'(empty_s), 32'(n == 0));
    chk("std.almost_full",  32'(af_s),    32'(n >= AF));
    chk("std.almost_empty", 32'(ae_s),    32'(n <= AE));
    chk("std.overflow",     32'(ovf_s),   32'(exp_ovf));
    chk("std.underflow",    32'(udf_s),   32'(exp_udf));
    chk("std.data_out",     32'(dout_s),  32'(exp_dout_s));
    chk("fwft.count",        32'(count_f), 32'(n));
    chk("fwft.full",         32'(full_f),  32'(n == DEPTH));
    chk("fwft.empty",        32'(empty_f), 32'(n == 0));
    chk("fwft.almost_full",  32'(af_f),    32'(n >= AF));
    chk("fwft.almost_empty", 32'(ae_f),    32'(n <= AE));
    chk("fwft.overflow",     32'(ovf_f),   32'(exp_ovf));
    chk("fwft.underflow",    32'(udf_f),   32'(exp_udf));
    chk("fwft.data_out",     32'(dout_f),  32'(head));
  endtask

  // Driver: apply one cycle of inputs, advance the model at the edge,
  // then check 1 time unit after the edge.
  task automatic step(input bit w, input bit r, input logic [W-1:0] d,
                      input bit clr, input bit rst);
    bit was_full;
    bit was_empty;
    wr      = w;
    rd      = r;
    data_in = d;
    err_clr = clr;
    reset_n = ~rst;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      exp_ovf    = 1'b0;
      exp_udf    = 1'b0;
      exp_dout_s = '0;
    end else begin
      was_full  = (exp_q.size() == DEPTH);
      was_empty = (exp_q.size() == 0);
      if (r && !was_empty) exp_dout_s = exp_q.pop_front();
      if (w && !was_full)  exp_q.push_back(d);
      if (clr) begin
        exp_ovf = 1'b0;
        exp_udf = 1'b0;
      end else begin
        if (w && was_full) exp_ovf = 1'b1;
        if (r && was_empty) exp_udf = 1'b1;
      end
    end
    #1;
    check_all();
  endtask

  logic [W-1:0] fill_vals [8] = '{8'd104, 8'd105, 8'd95, 8'd116,
                                  8'd104, 8'd101, 8'd114, 8'd101};

  initial begin
    int  bias;
    bit  w, r, c, x;

    // Reset held for two cycles
    step(0, 0, '0, 0, 1);
    step(0, 0, '0, 0, 1);
    step(0, 0, '0, 0, 0);

    // Fill, overflow attempt, clear
    for (int i = 0; i < 8; i++) step(1, 0, fill_vals[i], 0, 0);
    step(1, 0, 8'd99, 0, 0);
    step(0, 0, '0, 1, 0);

    // Drain, underflow attempt, clear
    for (int i = 0; i < 8; i++) step(0, 1, '0, 0, 0);
    step(0, 1, '0, 0, 0);
    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 1, 0);

    // Concurrent write/read with pointer wrap
    for (int i = 0; i < 4; i++) step(1, 0, W'(10 + i), 0, 0);
    for (int i = 0; i < 12; i++) step(1, 1, W'(70 + i), 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, '0, 0, 0);
    step(1, 1, 8'd33, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 0, W'(40 + i), 0, 0);
    step(1, 1, 8'd50, 0, 0);
    step(1, 0, 8'd51, 0, 0);
    // Clear beats a simultaneous overflow, then overflow sets and clears
    step(1, 0, 8'd52, 1, 0);
    step(1, 0, 8'd53, 0, 0);
    step(0, 0, '0, 1, 0);

    // Fall-through sequence from a clean reset
    step(0, 0, '0, 0, 1);
    step(1, 0, 8'd79, 0, 0);
    step(0, 0, '0, 0, 0);
    step(1, 0, 8'd114, 0, 0);
    step(0, 1, '0, 0, 0);
    step(0, 1, '0, 0, 0);

    // Reset mid-operation with write and read requested
    for (int i = 0; i < 3; i++) step(1, 0, W'(200 + i), 0, 0);
    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 0, 0);
    for (int i = 0; i < 2; i++) step(1, 0, W'(210 + i), 0, 0);
    step(1, 1, 8'd222, 0, 1);
    step(0, 0, '0, 0, 0);
    step(0, 1, '0, 0, 0);
    step(0, 0, '0, 1, 0);

    // Randomised traffic alternating fill-heavy and drain-heavy phases
    for (int i = 0; i < 600; i++) begin
      bias = ((i / 40) % 2 == 0) ? 75 : 30;
      w = ($urandom_range(0, 99) < bias);
      r = ($urandom_range(0, 99) < (100 - bias));
      c = ($urandom_range(0, 15) == 0);
      x = ($urandom_range(0, 199) == 0);
      step(w, r, W'($urandom_range(0, 255)), c, x);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
